// File: rtl/uart_tx_arb_if.sv
// Bundle between the UART arbiter, its requesters and the transmitter.
// master = arbiter side, slave = requesters/transmitter side.
interface uart_tx_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
);
    logic [NUM_REQ-1:0]   i_req;
    logic [8*NUM_REQ-1:0] i_data;
    logic [NUM_REQ-1:0]   o_ack;
    logic [7:0]           o_tx_data;
    logic                 o_tx_valid;
    logic                 i_tx_accept;
    logic                 o_busy;
    logic [IDX_W-1:0]     o_grant;

    modport master (
        input  i_req,
        input  i_data,
        input  i_tx_accept,
        output o_ack,
        output o_tx_data,
        output o_tx_valid,
        output o_busy,
        output o_grant
    );

    modport slave (
        output i_req,
        output i_data,
        output i_tx_accept,
        input  o_ack,
        input  o_tx_data,
        input  o_tx_valid,
        input  o_busy,
        input  o_grant
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one 8-bit UART transmitter.
// One transfer in flight: IDLE -> SEND -> DRAIN -> IDLE.
module uart_tx_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    uart_tx_arb_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic [7:0]           data_q;
    logic                 valid_q;
    logic                 busy_q;
    logic [IDX_W-1:0]     grant_q;
    logic [IDX_W-1:0]     last_q;

    logic [IDX_W-1:0]     win_d;
    logic                 found_d;
    logic [7:0]           sel_d;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        logic [IDX_W-1:0] k;
        win_d   = '0;
        found_d = 1'b0;
        k       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = IDX_W'((int'(last_q) + i) % NUM_REQ);
            if (!found_d && bus.i_req[k]) begin
                found_d = 1'b1;
                win_d   = k;
            end
        end
    end

    // Winner's byte lane.
    always_comb begin
        sel_d = 8'h00;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (win_d == IDX_W'(j)) begin
                sel_d = bus.i_data[8*j +: 8];
            end
        end
    end

    // Control FSM; every output is a register updated here.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state_q <= IDLE;
            ack_q   <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
        end else begin
            ack_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (found_d) begin
                        data_q  <= sel_d;
                        grant_q <= win_d;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (bus.i_tx_accept) begin
                        valid_q <= 1'b0;
                        ack_q   <= NUM_REQ'(1) << grant_q;
                        last_q  <= grant_q;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!bus.i_tx_accept) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_ack      = ack_q;
    assign bus.o_tx_data  = data_q;
    assign bus.o_tx_valid = valid_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_grant    = grant_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with hand-computed expectations.
// Inputs change and outputs are sampled on the falling edge.
module tb_uart_tx_arb;
    logic clk;
    logic nrst;
    int   total;
    int   bad;

    uart_tx_arb_if #(.NUM_REQ(4), .IDX_W(2)) bus ();

    uart_tx_arb #(.NUM_REQ(4), .IDX_W(2)) dut (
        .i_clk  (clk),
        .i_nrst (nrst),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
    endtask

    // Wait (bounded) for valid, check the grant, then run one accept.
    task automatic xfer(input int idx, input logic [7:0] byt);
        for (int i = 0; i < 5 && bus.o_tx_valid !== 1'b1; i++) tick();
        chk("x_valid", bus.o_tx_valid, 1);
        chk("x_data", bus.o_tx_data, byt);
        chk("x_grant", bus.o_grant, idx);
        bus.i_tx_accept = 1'b1;
        tick();
        chk("x_ack", bus.o_ack, 32'(4'b0001 << idx));
        chk("x_vlow", bus.o_tx_valid, 0);
        bus.i_tx_accept = 1'b0;
        tick();
        chk("x_ack0", bus.o_ack, 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        nrst  = 1'b0;
        bus.i_req       = '0;
        bus.i_data      = '0;
        bus.i_tx_accept = 1'b0;
        tick();
        tick();
        chk("rst_valid", bus.o_tx_valid, 0);
        chk("rst_data", bus.o_tx_data, 8'h00);
        chk("rst_ack", bus.o_ack, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_grant", bus.o_grant, 0);
        nrst = 1'b1;

        // accept in IDLE is ignored
        bus.i_tx_accept = 1'b1;
        tick();
        chk("idle_acc_busy", bus.o_busy, 0);
        chk("idle_acc_ack", bus.o_ack, 0);
        bus.i_tx_accept = 1'b0;
        tick();

        // single request on lane 2, accept after 10 cycles
        bus.i_req  = 4'b0100;
        bus.i_data = 32'h00A5_0000;
        tick();
        chk("s_valid", bus.o_tx_valid, 1);
        chk("s_data", bus.o_tx_data, 8'hA5);
        chk("s_grant", bus.o_grant, 2);
        chk("s_busy", bus.o_busy, 1);
        repeat (9) tick();
        chk("s_hold", bus.o_tx_valid, 1);
        chk("s_noack", bus.o_ack, 0);
        bus.i_tx_accept = 1'b1;
        tick();
        chk("s_ack", bus.o_ack, 4'b0100);
        chk("s_vlow", bus.o_tx_valid, 0);
        chk("s_drain", bus.o_busy, 1);
        bus.i_req       = 4'b0000;
        bus.i_tx_accept = 1'b0;
        tick();
        chk("s_ack0", bus.o_ack, 0);
        chk("s_idle", bus.o_busy, 0);
        tick();
        chk("s_stay", bus.o_tx_valid, 0);

        // all requesting: order 0,1,2,3,0
        pulse_reset();
        bus.i_data = 32'h1312_1110;
        bus.i_req  = 4'b1111;
        xfer(0, 8'h10);
        xfer(1, 8'h11);
        xfer(2, 8'h12);
        xfer(3, 8'h13);
        xfer(0, 8'h10);
        bus.i_req = 4'b0000;
        tick();
        tick();

        // fairness between 0 and 1
        pulse_reset();
        bus.i_data = 32'h0000_2120;
        bus.i_req  = 4'b0011;
        xfer(0, 8'h20);
        xfer(1, 8'h21);
        xfer(0, 8'h20);
        xfer(1, 8'h21);
        bus.i_req = 4'b0000;
        tick();
        tick();

        // data stability: lane 1 changes during SEND
        bus.i_data = 32'h0000_3C00;
        bus.i_req  = 4'b0010;
        tick();
        chk("d_grant", bus.o_grant, 1);
        chk("d_data", bus.o_tx_data, 8'h3C);
        bus.i_data = 32'h0000_FF00;
        tick();
        chk("d_hold", bus.o_tx_data, 8'h3C);
        bus.i_tx_accept = 1'b1;
        tick();
        chk("d_ack", bus.o_ack, 4'b0010);
        chk("d_drain", bus.o_tx_data, 8'h3C);
        bus.i_req       = 4'b0000;
        bus.i_tx_accept = 1'b0;
        tick();
        tick();

        // reset during SEND abandons the transfer
        bus.i_data = 32'h5500_0077;
        bus.i_req  = 4'b1000;
        tick();
        chk("r_grant", bus.o_grant, 3);
        chk("r_valid", bus.o_tx_valid, 1);
        nrst      = 1'b0;
        bus.i_req = 4'b1001;
        tick();
        chk("r_vlow", bus.o_tx_valid, 0);
        chk("r_ack", bus.o_ack, 0);
        chk("r_g0", bus.o_grant, 0);
        chk("r_busy", bus.o_busy, 0);
        nrst = 1'b1;
        tick();
        chk("r_next", bus.o_grant, 0);
        chk("r_nval", bus.o_tx_data, 8'h77);

        // slow accept release keeps DRAIN
        bus.i_tx_accept = 1'b1;
        tick();
        chk("w_ack", bus.o_ack, 4'b0001);
        bus.i_req = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("w_busy", bus.o_busy, 1);
            chk("w_vlow", bus.o_tx_valid, 0);
            chk("w_ack0", bus.o_ack, 0);
        end
        bus.i_tx_accept = 1'b0;
        tick();
        chk("w_idle", bus.o_busy, 0);
        tick();
        chk("w_val", bus.o_tx_valid, 1);
        chk("w_grant", bus.o_grant, 1);
        bus.i_tx_accept = 1'b1;
        tick();
        bus.i_req       = 4'b0000;
        bus.i_tx_accept = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing one 8-bit UART transmitter; legal range 2..8.
REQ-002 Parameter: IDX_W, default 2, width of the grant index, equal to $clog2(NUM_REQ).
REQ-003 Port: i_clk  input  1  single clock; all logic samples on its rising edge.
REQ-004 Port: i_nrst  input  1  reset, synchronous, active-low.
REQ-005 Port: i_req  input  NUM_REQ  per-requester request; bit k high = requester k has a byte pending.
REQ-006 Port: i_data  input  8*NUM_REQ  packed bytes; requester k's byte is on bits [8k+7:8k].
REQ-007 Port: o_ack  output  NUM_REQ  one-cycle pulse on bit k when requester k's byte has been transmitted.
REQ-008 Port: o_tx_data  output  8  byte to the transmitter data input.
REQ-009 Port: o_tx_valid  output  1  to the transmitter valid input.
REQ-010 Port: i_tx_accept  input  1  from the transmitter accept output; high = byte fully sent.
REQ-011 Port: o_busy  output  1  high whenever state is not IDLE.
REQ-012 Port: o_grant  output  IDX_W  index of the current or most recent owner.

Function
REQ-013 States: IDLE, SEND, DRAIN, encoded in 2 bits; state is registered and all outputs are registered.
REQ-014 IDLE with any i_req bit set: select the winner round-robin, searching from (last+1) mod NUM_REQ upward with wrap; next edge latches o_tx_data from the winner's i_data, sets o_grant to the winner, sets o_tx_valid=1 and moves to SEND.
REQ-015 Latency: o_tx_valid is high on the first edge after the request is seen in IDLE.
REQ-016 IDLE with i_req all-zero: remain in IDLE with o_tx_valid=0.
REQ-017 SEND: hold o_tx_valid=1 and hold o_tx_data; o_tx_data ignores i_data changes after the grant edge.
REQ-018 SEND with i_tx_accept=1: next edge sets o_tx_valid=0, pulses o_ack[o_grant]=1, sets last to o_grant and moves to DRAIN.
REQ-019 DRAIN: o_ack returns to all-zero after exactly one cycle; move to IDLE on the first edge where i_tx_accept=0.
REQ-020 Arbitration is never performed in SEND or DRAIN, so there is at most one transfer in flight.
REQ-021 o_ack is one-hot or zero; at most one ack is issued per grant.
REQ-022 A requester whose i_req drops during SEND still has its transfer completed and still receives its o_ack.
REQ-023 A requester keeps i_req high until its o_ack.
REQ-024 A requester that re-asserts i_req immediately after its o_ack is served only after every other pending requester (fairness).
REQ-025 With all NUM_REQ requesters continuously requesting, the grant order is 0,1,...,NUM_REQ-1,0,... .
REQ-026 i_tx_accept high while in IDLE is ignored.
REQ-027 o_tx_valid is never high in DRAIN; this enforces the transmitter's rule that valid drops before the next byte is presented.

Reset
REQ-028 i_nrst low at a rising edge forces: state=IDLE, o_tx_valid=0, o_tx_data=8'h00, o_ack=0, o_busy=0, o_grant=0, and last=NUM_REQ-1, so requester 0 wins first.
REQ-029 Reset asserted mid-SEND or mid-DRAIN abandons the transfer: no o_ack is issued, and o_tx_valid is 0 after that edge.
REQ-030 Reset takes priority over every other condition on the same edge.

Verification
REQ-031 Single request: i_req=4'b0100, byte 8'hA5 on lane 2, accept returned 10 cycles later -> o_tx_valid next cycle, o_tx_data=8'hA5, o_grant=2, then a one-cycle o_ack=4'b0100 and return to IDLE after accept falls.
REQ-032 All requesting: i_req=4'b1111 held, lane k = 8'h10+k -> transmitted bytes 8'h10, 11, 12, 13, 10, with acks in the same order.
REQ-033 Fairness: i_req=4'b0011, requester 0 re-requests immediately after each ack -> order 0,1,0,1.
REQ-034 Data stability: i_data lane 1 changes from 8'h3C to 8'hFF during SEND -> o_tx_data stays 8'h3C until DRAIN.
REQ-035 Reset mid-transfer: i_nrst low for 1 cycle during SEND -> o_tx_valid=0, o_ack=0, o_grant=0, state IDLE; the next grant is requester 0 if it is requesting.
REQ-036 Slow accept release: i_tx_accept held high for 5 cycles after o_tx_valid falls -> the block stays in DRAIN, o_busy=1, no new grant until accept=0.
